// File: rtl/imm_decode_stage.sv
// imm_decode_stage: RV immediate decoder with a registered output stage and one-entry skid buffer.
// Tracks a saturating count of accepted illegal instructions.
module imm_decode_stage #(
   parameter int XLEN  = 32,
   parameter int CNT_W = 8
) (
   input  logic             clk,
   input  logic             rst_n,
   input  logic             flush,
   input  logic             in_valid,
   output logic             in_ready,
   input  logic [31:0]      inst_code,
   output logic             out_valid,
   input  logic             out_ready,
   output logic [XLEN-1:0]  imm_out,
   output logic [2:0]       imm_fmt,
   output logic             illegal,
   output logic [CNT_W-1:0] illegal_cnt
);
   logic [6:0]      op;
   logic [2:0]      f3;
   logic [5:0]      shamt;
   logic [XLEN-1:0] d_imm, skid_imm;
   logic [2:0]      d_fmt, skid_fmt;
   logic            d_ill, skid_ill, skid_valid, acc, xfer;
   function automatic logic [XLEN-1:0] sx(input logic [31:0] v);
      return XLEN'($signed(v));
   endfunction
   assign op   = inst_code[6:0];
   assign f3   = inst_code[14:12];
   assign acc  = in_valid & in_ready;
   assign xfer = out_valid & out_ready;
   // OP-IMM on RV64 uses a 6-bit shamt; OP-IMM-32 and RV32 use 5 bits
   assign shamt = (XLEN == 64 && op == 7'b0010011) ? inst_code[25:20] : {1'b0, inst_code[24:20]};
   always_comb begin
      d_imm = '0;
      d_fmt = 3'd7;
      case (op)
         7'b0000011, 7'b1100111: begin
            d_imm = sx({{20{inst_code[31]}}, inst_code[31:20]});
            d_fmt = 3'd1;
         end
         7'b0010011, 7'b0011011:
            if (op == 7'b0010011 || XLEN == 64) begin
               d_fmt = (f3 == 3'b001 || f3 == 3'b101) ? 3'd6 : 3'd1;
               d_imm = (d_fmt == 3'd6) ? XLEN'(shamt) : sx({{20{inst_code[31]}}, inst_code[31:20]});
            end
         7'b0100011: begin
            d_imm = sx({{20{inst_code[31]}}, inst_code[31:25], inst_code[11:7]});
            d_fmt = 3'd2;
         end
         7'b1100011: begin
            d_imm = sx({{19{inst_code[31]}}, inst_code[31], inst_code[7], inst_code[30:25], inst_code[11:8], 1'b0});
            d_fmt = 3'd3;
         end
         7'b0110111, 7'b0010111: begin
            d_imm = sx({inst_code[31:12], 12'b0});
            d_fmt = 3'd4;
         end
         7'b1101111: begin
            d_imm = sx({{11{inst_code[31]}}, inst_code[31], inst_code[19:12], inst_code[20], inst_code[30:21], 1'b0});
            d_fmt = 3'd5;
         end
         7'b1110011: begin
            d_imm = XLEN'(inst_code[31:20]);
            d_fmt = 3'd1;
         end
         7'b0110011: d_fmt = 3'd0;
         7'b0111011: d_fmt = (XLEN == 64) ? 3'd0 : 3'd7;
         default: ;
      endcase
      d_ill = d_fmt == 3'd7;
   end
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         out_valid   <= 1'b0;
         imm_out     <= '0;
         imm_fmt     <= 3'd0;
         illegal     <= 1'b0;
         skid_valid  <= 1'b0;
         skid_imm    <= '0;
         skid_fmt    <= 3'd0;
         skid_ill    <= 1'b0;
         in_ready    <= 1'b1;
         illegal_cnt <= '0;
      end else if (flush) begin
         out_valid  <= 1'b0;
         skid_valid <= 1'b0;
         in_ready   <= 1'b1;
      end else begin
         // skid can only be full while in_ready=0, so skid drain and accept never coincide
         if (!out_valid || xfer) begin
            out_valid <= skid_valid | acc;
            if (skid_valid) begin
               imm_out    <= skid_imm;
               imm_fmt    <= skid_fmt;
               illegal    <= skid_ill;
               skid_valid <= 1'b0;
               in_ready   <= 1'b1;
            end else if (acc) begin
               imm_out <= d_imm;
               imm_fmt <= d_fmt;
               illegal <= d_ill;
            end
         end else if (acc) begin
            skid_imm   <= d_imm;
            skid_fmt   <= d_fmt;
            skid_ill   <= d_ill;
            skid_valid <= 1'b1;
            in_ready   <= 1'b0;
         end
         if (acc && d_ill && illegal_cnt != '1)
            illegal_cnt <= illegal_cnt + CNT_W'(1);
      end
   end
endmodule

// File: tb/tb_imm_decode_stage.sv
// tb_imm_decode_stage: scoreboard bench driving RV32 and RV64 instances with identical stimulus.
// Expected immediates come from a hand-computed table; counts come from a saturating bench model.
module tb_imm_decode_stage;
   typedef struct packed {
      logic [31:0] inst;
      logic [31:0] e32;
      logic [2:0]  f32;
      logic [63:0] e64;
      logic [2:0]  f64;
   } ent_t;
   ent_t tbl [0:16] = '{
      {32'hFFF00093, 32'hFFFFFFFF, 3'd1, 64'hFFFFFFFFFFFFFFFF, 3'd1},
      {32'hFE000EE3, 32'hFFFFFFFC, 3'd3, 64'hFFFFFFFFFFFFFFFC, 3'd3},
      {32'h41F05013, 32'h0000001F, 3'd6, 64'h000000000000001F, 3'd6},
      {32'h800000B7, 32'h80000000, 3'd4, 64'hFFFFFFFF80000000, 3'd4},
      {32'h0000001B, 32'h00000000, 3'd7, 64'h0000000000000000, 3'd1},
      {32'h00000033, 32'h00000000, 3'd0, 64'h0000000000000000, 3'd0},
      {32'h0000003B, 32'h00000000, 3'd7, 64'h0000000000000000, 3'd0},
      {32'hFE000E23, 32'hFFFFFFFC, 3'd2, 64'hFFFFFFFFFFFFFFFC, 3'd2},
      {32'h0010006F, 32'h00000800, 3'd5, 64'h0000000000000800, 3'd5},
      {32'h8000006F, 32'hFFF00000, 3'd5, 64'hFFFFFFFFFFF00000, 3'd5},
      {32'hFFF02073, 32'h00000FFF, 3'd1, 64'h0000000000000FFF, 3'd1},
      {32'h80002003, 32'hFFFFF800, 3'd1, 64'hFFFFFFFFFFFFF800, 3'd1},
      {32'h03F01013, 32'h0000001F, 3'd6, 64'h000000000000003F, 3'd6},
      {32'h03F0101B, 32'h00000000, 3'd7, 64'h000000000000001F, 3'd6},
      {32'h12345017, 32'h12345000, 3'd4, 64'h0000000012345000, 3'd4},
      {32'h00000000, 32'h00000000, 3'd7, 64'h0000000000000000, 3'd7},
      {32'h7FF00067, 32'h000007FF, 3'd1, 64'h00000000000007FF, 3'd1}
   };
   logic        clk = 0, rst_n = 0, flush = 0, in_valid = 0, out_ready = 0;
   logic [31:0] inst_code = '0;
   logic        in_ready32, out_valid32, illegal32, in_ready64, out_valid64, illegal64;
   logic [31:0] imm_out32;
   logic [63:0] imm_out64;
   logic [2:0]  imm_fmt32, imm_fmt64;
   logic [7:0]  cnt32, cnt64;
   int          checks = 0, passed = 0, cur = 0, c32 = 0, c64 = 0;
   int          q[$];
   always #5 clk = ~clk;
   imm_decode_stage #(.XLEN(32), .CNT_W(8)) dut32 (
      .clk(clk), .rst_n(rst_n), .flush(flush), .in_valid(in_valid), .in_ready(in_ready32),
      .inst_code(inst_code), .out_valid(out_valid32), .out_ready(out_ready), .imm_out(imm_out32),
      .imm_fmt(imm_fmt32), .illegal(illegal32), .illegal_cnt(cnt32));
   imm_decode_stage #(.XLEN(64), .CNT_W(8)) dut64 (
      .clk(clk), .rst_n(rst_n), .flush(flush), .in_valid(in_valid), .in_ready(in_ready64),
      .inst_code(inst_code), .out_valid(out_valid64), .out_ready(out_ready), .imm_out(imm_out64),
      .imm_fmt(imm_fmt64), .illegal(illegal64), .illegal_cnt(cnt64));
   task automatic send(input int i);
      int n = 0;
      cur = i;
      inst_code = tbl[i].inst;
      in_valid = 1;
      @(negedge clk);
      while (!in_ready32 && n < 50) begin
         @(negedge clk);
         n++;
      end
      if (!in_ready32) begin
         checks++;
         $display("FAIL send_timeout got in_ready=0 exp 1 within 50 cycles");
      end
      @(posedge clk);
      #1;
      in_valid = 0;
   endtask
   task automatic drain();
      int n = 0;
      while (q.size() != 0 && n < 20) begin
         @(posedge clk);
         n++;
      end
      #1;
      checks++;
      if (q.size() != 0) $display("FAIL drain got %0d pending exp 0", q.size());
      else passed++;
   endtask
   task automatic test_reset();
      checks += 2;
      if ({out_valid32, in_ready32, imm_out32, imm_fmt32, illegal32, cnt32} !== {1'b0, 1'b1, 32'h0, 3'd0, 1'b0, 8'd0})
         $display("FAIL reset32 got v=%b r=%b imm=%h fmt=%0d ill=%b cnt=%0d exp 0 1 0 0 0 0", out_valid32, in_ready32, imm_out32, imm_fmt32, illegal32, cnt32);
      else passed++;
      if ({out_valid64, in_ready64, imm_out64, imm_fmt64, illegal64, cnt64} !== {1'b0, 1'b1, 64'h0, 3'd0, 1'b0, 8'd0})
         $display("FAIL reset64 got v=%b r=%b imm=%h fmt=%0d ill=%b cnt=%0d exp 0 1 0 0 0 0", out_valid64, in_ready64, imm_out64, imm_fmt64, illegal64, cnt64);
      else passed++;
   endtask
   task automatic test_decode();
      out_ready = 1;
      send(0);
      checks++;
      if ({out_valid32, imm_out32, imm_fmt32} !== {1'b1, 32'hFFFFFFFF, 3'd1})
         $display("FAIL latency got v=%b imm=%h fmt=%0d exp 1 ffffffff 1", out_valid32, imm_out32, imm_fmt32);
      else passed++;
      for (int i = 1; i < 17; i++) send(i);
      drain();
   endtask
   task automatic test_back_to_back();
      out_ready = 0;
      send(1);
      send(2);
      checks++;
      if ({in_ready32, in_ready64} !== 2'b00) $display("FAIL skid_full got in_ready=%b%b exp 00", in_ready32, in_ready64);
      else passed++;
      cur = 3;
      inst_code = tbl[3].inst;
      in_valid = 1;
      repeat (3) @(negedge clk);
      checks++;
      if ({out_valid32, imm_out32, in_ready32} !== {1'b1, tbl[1].e32, 1'b0} || q.size() != 2)
         $display("FAIL hold got v=%b imm=%h r=%b pend=%0d exp 1 %h 0 2", out_valid32, imm_out32, in_ready32, q.size(), tbl[1].e32);
      else passed++;
      @(posedge clk);
      #1;
      out_ready = 1;
      send(3);
      drain();
   endtask
   task automatic test_flush_accept();
      out_ready = 1;
      flush = 1;
      send(15);
      flush = 0;
      checks += 2;
      if ({out_valid32, in_ready32} !== 2'b01) $display("FAIL flush_acc_v got v=%b r=%b exp 0 1", out_valid32, in_ready32);
      else passed++;
      if (cnt32 !== 8'(c32) || cnt64 !== 8'(c64)) $display("FAIL flush_acc_cnt got %0d/%0d exp %0d/%0d", cnt32, cnt64, c32, c64);
      else passed++;
   endtask
   task automatic test_illegal_sat();
      out_ready = 1;
      repeat (300) send(15);
      drain();
      checks++;
      if ({cnt32, cnt64} !== {8'd255, 8'd255}) $display("FAIL sat_cnt got %0d/%0d exp 255/255", cnt32, cnt64);
      else passed++;
      out_ready = 0;
      send(0);
      send(1);
      flush = 1;
      @(posedge clk);
      #1;
      flush = 0;
      checks++;
      if ({out_valid32, in_ready32, out_valid64, in_ready64, cnt32, cnt64} !== {4'b0101, 8'd255, 8'd255})
         $display("FAIL flush_full got v=%b r=%b cnt=%0d exp 0 1 255", out_valid32, in_ready32, cnt32);
      else passed++;
      out_ready = 1;
   endtask
   task automatic test_async_reset();
      out_ready = 0;
      send(2);
      send(3);
      #2;
      rst_n = 0;
      #1;
      q.delete();
      c32 = 0;
      c64 = 0;
      test_reset();
      cur = 0;
      inst_code = tbl[0].inst;
      in_valid = 1;
      out_ready = 1;
      repeat (2) @(posedge clk);
      #1;
      checks++;
      if (out_valid32 !== 1'b0) $display("FAIL rst_ignore got v=%b exp 0", out_valid32);
      else passed++;
      rst_n = 1;
      @(posedge clk);
      #1;
      in_valid = 0;
      checks++;
      if (out_valid32 !== 1'b1) $display("FAIL rst_resume got v=%b exp 1", out_valid32);
      else passed++;
      drain();
   endtask
   initial begin
      fork
         forever begin
            int k;
            @(negedge clk);
            if (rst_n) begin
               if (out_valid32 && out_ready) begin
                  checks++;
                  if (q.size() == 0) $display("FAIL sb_extra got output exp none pending");
                  else begin
                     k = q.pop_front();
                     if ({imm_out32, imm_fmt32, illegal32} !== {tbl[k].e32, tbl[k].f32, tbl[k].f32 == 3'd7})
                        $display("FAIL sb32 inst %h got %h/%0d/%b exp %h/%0d", tbl[k].inst, imm_out32, imm_fmt32, illegal32, tbl[k].e32, tbl[k].f32);
                     else passed++;
                     checks++;
                     if ({out_valid64, imm_out64, imm_fmt64, illegal64} !== {1'b1, tbl[k].e64, tbl[k].f64, tbl[k].f64 == 3'd7})
                        $display("FAIL sb64 inst %h got %b/%h/%0d/%b exp 1/%h/%0d", tbl[k].inst, out_valid64, imm_out64, imm_fmt64, illegal64, tbl[k].e64, tbl[k].f64);
                     else passed++;
                  end
               end
               if (flush) q.delete();
               else if (in_valid && in_ready32) begin
                  q.push_back(cur);
                  if (tbl[cur].f32 == 3'd7 && c32 < 255) c32++;
                  if (tbl[cur].f64 == 3'd7 && c64 < 255) c64++;
               end
            end
         end
      join_none
      repeat (3) @(posedge clk);
      #1;
      rst_n = 1;
      test_reset();
      test_decode();
      test_back_to_back();
      test_flush_accept();
      test_illegal_sat();
      test_async_reset();
      $display("%0d/%0d checks passed", passed, checks);
      $finish;
   end
endmodule

// File: doc/imm_decode_stage.md
IMM_DECODE_STAGE -- requirements
Module: imm_decode_stage

Interface
REQ-001 SHALL have parameter XLEN, default 32, output immediate width; legal values 32 and 64 only.
REQ-002 SHALL have parameter CNT_W, default 8, width of the illegal-instruction counter.
REQ-003 SHALL have port clk  input  1  single clock; all state updates on its rising edge.
REQ-004 SHALL have port rst_n  input  1  asynchronous reset, active-low.
REQ-005 SHALL have port flush  input  1  synchronous pipeline flush.
REQ-006 SHALL have port in_valid  input  1  inst_code is valid.
REQ-007 SHALL have port in_ready  output  1  block can accept an instruction.
REQ-008 SHALL have port inst_code  input  32  raw RV instruction word.
REQ-009 SHALL have port out_valid  output  1  imm_out, imm_fmt and illegal are valid.
REQ-010 SHALL have port out_ready  input  1  downstream accepts the result.
REQ-011 SHALL have port imm_out  output  XLEN  decoded immediate.
REQ-012 SHALL have port imm_fmt  output  3  format code: 0 R, 1 I, 2 S, 3 B, 4 U, 5 J, 6 SHAMT, 7 ILLEGAL.
REQ-013 SHALL have port illegal  output  1  opcode not supported for this XLEN.
REQ-014 SHALL have port illegal_cnt  output  CNT_W  saturating count of accepted illegal instructions.

Function
REQ-015 SHALL decode on opcode inst_code[6:0]; all sign extension is from inst_code[31] to XLEN bits.
REQ-016 SHALL decode 0000011 (load) and 1100111 (JALR) as I: sign-extended inst[31:20].
REQ-017 SHALL decode 0010011 as I, except funct3 001/101 as SHAMT: zero-extended inst[24:20] (XLEN=32) or inst[25:20] (XLEN=64).
REQ-018 SHALL decode 0011011 like 0010011, with a 5-bit shamt, when XLEN=64; when XLEN=32 it is ILLEGAL.
REQ-019 SHALL decode 0100011 as S: sign-extended {inst[31:25],inst[11:7]}.
REQ-020 SHALL decode 1100011 as B: sign-extended {inst[31],inst[7],inst[30:25],inst[11:8],0}.
REQ-021 SHALL decode 0110111 and 0010111 as U: {inst[31:12],12'b0}, sign-extended.
REQ-022 SHALL decode 1101111 as J: sign-extended {inst[31],inst[19:12],inst[20],inst[30:21],0}.
REQ-023 SHALL decode 1110011 as I with imm zero-extended inst[31:20] (CSR address).
REQ-024 SHALL decode 0110011, and 0111011 when XLEN=64, as R with imm 0.
REQ-025 SHALL decode any other opcode as imm 0, fmt 7, illegal=1.
REQ-026 SHALL register the result in a main stage (out_*) plus a one-entry skid register; latency from input handshake to out_valid is exactly 1 cycle.
REQ-027 SHALL define an accept as in_valid&in_ready and an output transfer as out_valid&out_ready; throughput is 1 per cycle while out_ready=1.
REQ-028 SHALL drive in_ready = !skid_valid, from a register only.
REQ-029 SHALL route an accept with the main stage full and no output transfer into the skid register.
REQ-030 SHALL move skid contents to the main stage on an output transfer, preserving order; an accept in the same cycle goes into the skid.
REQ-031 SHALL hold out_* stable while out_valid=1 and out_ready=0.
REQ-032 SHALL, on flush=1, clear main and skid valid next cycle; flush overrides a same-cycle accept, whose instruction is discarded and not counted.
REQ-033 SHALL increment illegal_cnt on each accepted illegal instruction, saturating at 2^CNT_W-1; flush does not clear it.

Reset
REQ-034 SHALL, when rst_n=0, immediately force out_valid=0, skid empty, in_ready=1, imm_out=0, imm_fmt=0, illegal=0, illegal_cnt=0, including mid-transfer.
REQ-035 SHALL ignore in_valid while rst_n=0 and resume accepting on the first rising edge after deassertion.

Verification
REQ-036 SHALL cover: XLEN=32, inst 0xFFF00093, out_ready=1 -> next cycle out_valid=1, imm_out=0xFFFFFFFF, fmt=1.
REQ-037 SHALL cover: inst 0xFE000EE3 -> imm_out=0xFFFFFFFC, fmt=3; inst 0x41F05013 (srai) -> imm_out=0x1F, fmt=6.
REQ-038 SHALL cover: XLEN=64, inst 0x800000B7 -> imm_out=0xFFFFFFFF80000000, fmt=4; inst 0x0000001B -> illegal=0.
REQ-039 SHALL cover: out_ready=0, push A then B -> in_ready=0 after B, C held off; out_ready=1 -> A, B, C emitted in order, none lost or duplicated.
REQ-040 SHALL cover: CNT_W=8, 300 accepts of 0x00000000 -> illegal=1, fmt=7, illegal_cnt=255; then flush with both stages full -> out_valid=0 and in_ready=1 next cycle, illegal_cnt=255.
REQ-041 SHALL cover: rst_n asserted asynchronously mid-cycle with skid full -> outputs at reset values before the next clock edge.
